// File: rtl/i2c_tx_feeder.sv
// Transmit byte source for the APB-driven I2C master sequencer: payload FIFO, address register and frame phase tracker.
// Optional INT synchronizer enabled by defining I2C_FEEDER_INT_SYNC_EN.
module i2c_tx_feeder #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned AW          = 4,
    parameter int unsigned PAYLOAD_LEN = 4
) (
    input  logic          PCLK,
    input  logic          PRESETN,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          addr_load,
    input  logic [6:0]    slave_addr,
    input  logic          flush,
    input  logic          clr_err,
    input  logic          INT,
    output logic [7:0]    ADDR,
    output logic [7:0]    data_in,
    output logic          frame_ready,
    output logic          frame_done,
    output logic [2:0]    phase,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic          spurious_int
);

    localparam int unsigned CW      = AW + 1;
    localparam logic [2:0]  LAST_PH = 3'(PAYLOAD_LEN + 2);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN} state_t;

    state_t         state, state_nx;
    logic [2:0]     phase_nx;
    logic           pop, done_set, spur_set;
    logic           wr_acc, ovf_set, int_pulse;
    logic [AW-1:0]  wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
    logic [CW-1:0]  count_nx;
    logic [7:0]     mem [DEPTH];

`ifdef I2C_FEEDER_INT_SYNC_EN
    logic int_s1, int_s2, int_q;

    // Two-flop synchronizer followed by the edge register
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            int_s1 <= 1'b0;
            int_s2 <= 1'b0;
            int_q  <= 1'b0;
        end else begin
            int_s1 <= INT;
            int_s2 <= int_s1;
            int_q  <= int_s2;
        end
    end

    assign int_pulse = int_s2 & ~int_q;
`else
    logic int_q;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) int_q <= 1'b0;
        else          int_q <= INT;
    end

    assign int_pulse = INT & ~int_q;
`endif

    // State register
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) state <= S_IDLE;
        else          state <= state_nx;
    end

    // Next state, phase advance and pop decision
    always_comb begin
        state_nx = state;
        phase_nx = phase;
        pop      = 1'b0;
        done_set = 1'b0;
        spur_set = 1'b0;
        if (flush) begin
            state_nx = S_IDLE;
            phase_nx = 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    spur_set = int_pulse;
                    if (count >= CW'(PAYLOAD_LEN)) state_nx = S_ARMED;
                end
                S_ARMED: begin
                    if (int_pulse) begin
                        phase_nx = 3'd1;
                        state_nx = S_RUN;
                    end
                end
                S_RUN: begin
                    if (int_pulse) begin
                        if (phase == LAST_PH) begin
                            phase_nx = 3'd0;
                            done_set = 1'b1;
                            state_nx = S_IDLE;
                        end else begin
                            phase_nx = phase + 3'd1;
                            pop      = (phase >= 3'd2);
                        end
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // FIFO bookkeeping; a pop frees a slot for a same-cycle write
    always_comb begin
        wr_acc    = wr_en & ~flush & (~full | pop);
        ovf_set   = wr_en & ~flush & ~wr_acc;
        wr_ptr_nx = wr_ptr;
        rd_ptr_nx = rd_ptr;
        count_nx  = count;
        if (flush) begin
            wr_ptr_nx = '0;
            rd_ptr_nx = '0;
            count_nx  = '0;
        end else begin
            if (wr_acc) wr_ptr_nx = wr_ptr + AW'(1);
            if (pop)    rd_ptr_nx = rd_ptr + AW'(1);
            count_nx = count + CW'(wr_acc) - CW'(pop);
        end
    end

    always_ff @(posedge PCLK) begin
        if (wr_acc) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            phase        <= 3'd0;
            frame_ready  <= 1'b0;
            frame_done   <= 1'b0;
            overflow     <= 1'b0;
            spurious_int <= 1'b0;
            ADDR         <= 8'h00;
            data_in      <= 8'h00;
        end else begin
            wr_ptr       <= wr_ptr_nx;
            rd_ptr       <= rd_ptr_nx;
            count        <= count_nx;
            full         <= (count_nx == CW'(DEPTH));
            empty        <= (count_nx == '0);
            phase        <= phase_nx;
            frame_ready  <= (state_nx != S_IDLE);
            frame_done   <= done_set;
            overflow     <= (overflow & ~clr_err) | ovf_set;
            spurious_int <= (spurious_int & ~clr_err) | spur_set;
            if (addr_load) ADDR <= {slave_addr, 1'b0};
            // Empty FIFO keeps the last presented byte
            if (count != '0) data_in <= mem[rd_ptr];
        end
    end

endmodule
